// File: rtl/batpu_mem_io.sv
// BatPU data memory and memory-mapped I/O: 240 B RAM plus screen,
// character, number, RNG and controller registers at 240..255.
module batpu_mem_io #(
  parameter logic [7:0] LFSR_SEED  = 8'h01,
  parameter int         CHAR_SLOTS = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              cpu_addr,
  input  logic [7:0]              cpu_wdata,
  input  logic                    cpu_we,
  output logic [7:0]              cpu_rdata,
  input  logic [7:0]              ctrl_in,
  output logic [4:0]              scr_x,
  output logic [4:0]              scr_y,
  input  logic                    scr_pix_rd,
  output logic                    scr_draw,
  output logic                    scr_clr,
  output logic                    scr_push,
  output logic                    scr_wipe,
  output logic [5*CHAR_SLOTS-1:0] char_disp,
  output logic [7:0]              num_val,
  output logic                    num_valid,
  output logic                    num_signed
);

  localparam int PW = $clog2(CHAR_SLOTS + 1);
  localparam logic [7:0] SEED =
    (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  logic [7:0]              ram [240];
  logic [7:0]              lfsr;
  logic [7:0]              ctrl_meta;
  logic [7:0]              ctrl_sync;
  logic [5*CHAR_SLOTS-1:0] stage;
  logic [PW-1:0]           wr_ptr;
  logic                    is_ram;
  logic                    ram_we;
  logic                    io_we;

  assign is_ram = (cpu_addr < 8'd240);
  assign ram_we = rst_n && cpu_we && is_ram;
  assign io_we  = cpu_we && !is_ram;

  always_ff @(posedge clk) begin
    if (ram_we) ram[cpu_addr] <= cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr       <= SEED;
      ctrl_meta  <= '0;
      ctrl_sync  <= '0;
      scr_x      <= '0;
      scr_y      <= '0;
      scr_draw   <= 1'b0;
      scr_clr    <= 1'b0;
      scr_push   <= 1'b0;
      scr_wipe   <= 1'b0;
      stage      <= '0;
      wr_ptr     <= '0;
      char_disp  <= '0;
      num_val    <= '0;
      num_valid  <= 1'b0;
      num_signed <= 1'b0;
    end else begin
      // taps 8,6,5,4 -> bits 7,5,4,3
      lfsr      <= {lfsr[6:0], ^(lfsr & 8'hB8)};
      ctrl_meta <= ctrl_in;
      ctrl_sync <= ctrl_meta;
      scr_draw  <= io_we && (cpu_addr == 8'd242);
      scr_clr   <= io_we && (cpu_addr == 8'd243);
      scr_push  <= io_we && (cpu_addr == 8'd245);
      scr_wipe  <= io_we && (cpu_addr == 8'd246);
      if (io_we) begin
        case (cpu_addr)
          8'd240: scr_x <= cpu_wdata[4:0];
          8'd241: scr_y <= cpu_wdata[4:0];
          8'd247: begin
            if (wr_ptr < PW'(CHAR_SLOTS)) begin
              for (int i = 0; i < CHAR_SLOTS; i++)
                if (wr_ptr == PW'(i))
                  stage[5*i +: 5] <= cpu_wdata[4:0];
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
          8'd248: char_disp <= stage;
          8'd249: begin
            stage  <= '0;
            wr_ptr <= '0;
          end
          8'd250: begin
            num_val   <= cpu_wdata;
            num_valid <= 1'b1;
          end
          8'd251: num_valid  <= 1'b0;
          8'd252: num_signed <= 1'b1;
          8'd253: num_signed <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cpu_rdata = 8'h00;
    unique case (1'b1)
      is_ram:                 cpu_rdata = ram[cpu_addr];
      (cpu_addr == 8'd244):   cpu_rdata = {7'b0, scr_pix_rd};
      (cpu_addr == 8'd254):   cpu_rdata = lfsr;
      (cpu_addr == 8'd255):   cpu_rdata = ctrl_sync;
      default:                cpu_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_batpu_mem_io.sv
// Bench for batpu_mem_io: directed scenarios followed by random
// bus traffic checked against a behavioural model of the memory map.
module tb_batpu_mem_io;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cpu_addr, cpu_wdata, cpu_rdata, ctrl_in;
  logic        cpu_we, scr_pix_rd;
  logic [4:0]  scr_x, scr_y;
  logic        scr_draw, scr_clr, scr_push, scr_wipe;
  logic [49:0] char_disp;
  logic [7:0]  num_val;
  logic        num_valid, num_signed;

  batpu_mem_io dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .ctrl_in(ctrl_in),
    .scr_x(scr_x), .scr_y(scr_y), .scr_pix_rd(scr_pix_rd),
    .scr_draw(scr_draw), .scr_clr(scr_clr),
    .scr_push(scr_push), .scr_wipe(scr_wipe),
    .char_disp(char_disp),
    .num_val(num_val), .num_valid(num_valid),
    .num_signed(num_signed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model
  logic [7:0]  mram [240];
  bit          mval [240];
  logic [4:0]  mx, my;
  logic        md, mc, mp, mw;
  logic [4:0]  mstage [$];
  logic [49:0] mdisp;
  logic [7:0]  mnum;
  logic        mnv, msg;
  int          lcount;
  logic [7:0]  lseq [255];
  logic [7:0]  mc1, mc2;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [49:0] pack_stage();
    logic [49:0] v = '0;
    for (int i = 0; i < mstage.size(); i++) v[5*i +: 5] = mstage[i];
    return v;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mstage.delete(); mdisp = '0;
    mnum = 0; mnv = 0; msg = 0; lcount = 0; mc1 = 0; mc2 = 0;
  endtask

  task automatic model_store(input logic [7:0] a, input logic [7:0] d);
    if (a < 240) begin
      mram[a] = d; mval[a] = 1'b1;
    end else begin
      case (a)
        8'd240: mx = d[4:0];
        8'd241: my = d[4:0];
        8'd247: if (mstage.size() < 10) mstage.push_back(d[4:0]);
        8'd248: mdisp = pack_stage();
        8'd249: mstage.delete();
        8'd250: begin mnum = d; mnv = 1'b1; end
        8'd251: mnv = 1'b0;
        8'd252: msg = 1'b1;
        8'd253: msg = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    md = 0; mc = 0; mp = 0; mw = 0;
    if (!rst_n) model_reset();
    else begin
      lcount++;
      mc2 = mc1; mc1 = ctrl_in;
      if (cpu_we) begin
        md = (cpu_addr == 8'd242); mc = (cpu_addr == 8'd243);
        mp = (cpu_addr == 8'd245); mw = (cpu_addr == 8'd246);
        model_store(cpu_addr, cpu_wdata);
      end
    end
    #1;
  endtask

  function automatic logic [7:0] exp_read(input logic [7:0] a);
    if (a < 240) return mram[a];
    case (a)
      8'd244:  return {7'b0, scr_pix_rd};
      8'd254:  return lseq[lcount % 255];
      8'd255:  return mc2;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".x"}, scr_x, mx);
    chk({tag, ".y"}, scr_y, my);
    chk({tag, ".draw"}, scr_draw, md);
    chk({tag, ".clr"}, scr_clr, mc);
    chk({tag, ".push"}, scr_push, mp);
    chk({tag, ".wipe"}, scr_wipe, mw);
    chk({tag, ".chars"}, char_disp, mdisp);
    chk({tag, ".num"}, num_val, mnum);
    chk({tag, ".nv"}, num_valid, mnv);
    chk({tag, ".ns"}, num_signed, msg);
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a,
                    output logic [7:0] v);
    cpu_addr = a; cpu_we = 1'b0;
    #1;
    v = cpu_rdata;
    chk(tag, v, exp_read(a));
  endtask

  initial begin
    logic [7:0]  s, v, v0;
    logic [49:0] e;

    s = 8'h01;
    for (int i = 0; i < 255; i++) begin
      lseq[i] = s;
      s = {s[6:0], ^(s & 8'hB8)};
    end

    rst_n = 0; cpu_addr = 0; cpu_wdata = 0; cpu_we = 0;
    ctrl_in = 0; scr_pix_rd = 0;
    model_reset();
    tick(); tick();
    rst_n = 1;
    chk("rst.x", scr_x, 5'd0);
    chk("rst.chars", char_disp, 50'd0);
    chk("rst.nv", num_valid, 1'b0);
    check_outs("rst");

    // T1 RAM
    store(8'd0, 8'hA5);
    store(8'd239, 8'h3C);
    rd("t1.ram0", 8'd0, v);     chk("t1.ram0c", v, 8'hA5);
    rd("t1.ram239", 8'd239, v); chk("t1.ram239c", v, 8'h3C);
    rd("t1.io240", 8'd240, v);  chk("t1.io240c", v, 8'h00);

    // T2 screen
    store(8'd240, 8'd7);
    store(8'd241, 8'd31);
    store(8'd242, 8'h99);
    chk("t2.draw", scr_draw, 1'b1);
    chk("t2.x", scr_x, 5'd7);
    chk("t2.y", scr_y, 5'd31);
    check_outs("t2a");
    tick();
    chk("t2.draw_off", scr_draw, 1'b0);
    store(8'd240, 8'hFF);
    chk("t2.xsat", scr_x, 5'd31);
    store(8'd243, 0); check_outs("t2clr");
    store(8'd245, 0); check_outs("t2push");
    store(8'd246, 0); check_outs("t2wipe");
    scr_pix_rd = 1;
    rd("t2.pix", 8'd244, v); chk("t2.pixc", v, 8'h01);

    // T3 chars
    store(8'd249, 0);
    for (int i = 1; i <= 11; i++) store(8'd247, 8'(i));
    store(8'd248, 0);
    e = '0;
    for (int i = 0; i < 10; i++) e[5*i +: 5] = 5'(i + 1);
    chk("t3.commit", char_disp, e);
    store(8'd249, 0);
    chk("t3.clr_keep", char_disp, e);
    store(8'd247, 8'd21);
    store(8'd248, 0);
    chk("t3.slot0", char_disp, 50'd21);
    check_outs("t3");

    // T4 number
    store(8'd250, 8'h80);
    store(8'd252, 0);
    chk("t4.val", num_val, 8'h80);
    chk("t4.nv", num_valid, 1'b1);
    chk("t4.ns", num_signed, 1'b1);
    store(8'd251, 0);
    chk("t4.nv0", num_valid, 1'b0);
    chk("t4.keep", num_val, 8'h80);
    store(8'd253, 0);
    check_outs("t4");

    // T5 RNG and controller
    rst_n = 0; tick(); rst_n = 1;
    rd("t5.r0", 8'd254, v); chk("t5.r0c", v, 8'h01);
    tick();
    rd("t5.r1", 8'd254, v); chk("t5.r1c", v, 8'h02);
    tick();
    rd("t5.r2", 8'd254, v); chk("t5.r2c", v, 8'h04);
    v0 = v;
    for (int i = 0; i < 255; i++) begin
      tick();
      rd("t5.seq", 8'd254, v);
      chk("t5.nz", (v != 8'h00), 1'b1);
      if (i < 254) chk("t5.noearly", (v == v0), 1'b0);
    end
    chk("t5.period", v, v0);
    ctrl_in = 8'h5A;
    tick(); tick();
    rd("t5.ctrl", 8'd255, v); chk("t5.ctrlc", v, 8'h5A);

    // T6 reset beats stores
    rst_n = 0;
    store(8'd242, 0);
    chk("t6.draw", scr_draw, 1'b0);
    store(8'd250, 8'h33);
    chk("t6.nv", num_valid, 1'b0);
    chk("t6.num", num_val, 8'h00);
    rd("t6.lfsr", 8'd254, v); chk("t6.lfsrc", v, 8'h01);
    check_outs("t6");
    rst_n = 1;

    // random traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      logic [7:0] a, d;
      r = $urandom_range(0, 9);
      scr_pix_rd = 1'($urandom);
      if ($urandom_range(0, 7) == 0) ctrl_in = 8'($urandom);
      a = 8'($urandom_range(0, 239));
      d = 8'($urandom);
      if (r <= 2) begin
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
        #1;
        if (mval[a]) chk("rnd.rdw_old", cpu_rdata, mram[a]);
        tick(); cpu_we = 1'b0;
      end else if (r <= 4) begin
        if (mval[a]) rd("rnd.ram", a, v);
        tick();
      end else if (r <= 7) begin
        store(8'(240 + $urandom_range(0, 15)), d);
      end else begin
        rd("rnd.io", 8'(240 + $urandom_range(0, 15)), v);
        tick();
      end
      check_outs("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
